// File: rtl/core_pkg.sv
// Shared types and defaults for the core run sequencer.
package core_pkg;

  localparam int unsigned PC_W_DEF = 8;
  localparam logic [PC_W_DEF-1:0] DONE_PC_DEF = {PC_W_DEF{1'b1}};

  typedef enum logic [2:0] {
    IDLE,
    RST_HOLD,
    RUN,
    DONE,
    TOUT
  } run_state_t;

  // Out-of-range bank requests map onto the last implemented bank.
  function automatic int unsigned clamp_bank(input int unsigned sel, input int unsigned num_progs);
    return (sel >= num_progs) ? num_progs - 1 : sel;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Registered up-counter with synchronous clear that holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/core_run_ctrl.sv
// Run sequencer: start edge -> timed core reset -> run until terminal PC,
// watchdog or abort, then park the core in reset with sticky status.
module core_run_ctrl
  import core_pkg::*;
#(
  parameter int unsigned     PC_W       = PC_W_DEF,
  parameter logic [PC_W-1:0] DONE_PC    = {PC_W{1'b1}},
  parameter int unsigned     NUM_PROGS  = 4,
  parameter int unsigned     BANK_W     = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1,
  parameter int unsigned     RST_CYCLES = 2,
  parameter int unsigned     CYC_W      = 16,
  parameter int unsigned     TIMEOUT    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [BANK_W-1:0] prog_sel,
  input  logic [PC_W-1:0]   pc,
  output logic              core_rst,
  output logic [BANK_W-1:0] bank,
  output logic              busy,
  output logic              done,
  output logic              timed_out,
  output logic [CYC_W-1:0]  cycles
);

  localparam int unsigned HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int unsigned CMP_W  = (CYC_W >= 32) ? CYC_W + 1 : 33;

  run_state_t state_q, state_d;

  logic              start_q;
  logic              start_edge;
  logic              accept;
  logic [HOLD_W-1:0] hold_q;
  logic              hold_last;
  logic              pc_hit;
  logic              wd_hit;
  logic              cnt_en;
  logic [BANK_W-1:0] sel_clamped;

  logic              core_rst_d;
  logic              busy_d;
  logic              done_d;
  logic              timed_out_d;
  logic [BANK_W-1:0] bank_d;

  assign start_edge  = start & ~start_q;
  assign accept      = start_edge && ((state_q == IDLE) || (state_q == DONE) || (state_q == TOUT));
  assign hold_last   = (hold_q == HOLD_W'(RST_CYCLES - 1));
  assign pc_hit      = (pc == DONE_PC);
  assign wd_hit      = (TIMEOUT != 0) && ((CMP_W'(cycles) + CMP_W'(1)) == CMP_W'(TIMEOUT));
  // The watchdog limit equals cycles+1, so the count step covers both cases.
  assign cnt_en      = (state_q == RUN) && !abort && !pc_hit;
  assign sel_clamped = BANK_W'(clamp_bank(32'(prog_sel), NUM_PROGS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, TOUT: begin
        if (start_edge) state_d = RST_HOLD;
      end
      RST_HOLD: begin
        if (abort)          state_d = IDLE;
        else if (hold_last) state_d = RUN;
      end
      RUN: begin
        if (abort)       state_d = IDLE;
        else if (pc_hit) state_d = DONE;
        else if (wd_hit) state_d = TOUT;
      end
      default: state_d = IDLE;
    endcase
  end

  // Status outputs follow the state being entered, so they register in step.
  always_comb begin
    core_rst_d  = (state_d != RUN);
    busy_d      = (state_d == RST_HOLD) || (state_d == RUN);
    done_d      = (state_d == DONE);
    timed_out_d = (state_d == TOUT);
    bank_d      = accept ? sel_clamped : bank;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_rst  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      timed_out <= 1'b0;
      bank      <= '0;
    end else begin
      core_rst  <= core_rst_d;
      busy      <= busy_d;
      done      <= done_d;
      timed_out <= timed_out_d;
      bank      <= bank_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      start_q <= start;
      if (accept) begin
        hold_q <= '0;
      end else if ((state_q == RST_HOLD) && !hold_last) begin
        hold_q <= hold_q + HOLD_W'(1);
      end
    end
  end

  sat_counter #(
    .W (CYC_W)
  ) u_cycles (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .en    (cnt_en),
    .count (cycles)
  );

endmodule

// File: tb/tb_core_run_ctrl.sv
// Scoreboard bench: two differently parametrised sequencers share stimulus and
// are checked every cycle against a countdown-style reference model.
module tb_core_run_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] pc = 8'h00;
  logic [1:0] prog_sel = 2'd0;

  logic       a_core_rst, a_busy, a_done, a_to;
  logic [1:0] a_bank;
  logic [3:0] a_cycles;
  logic       b_core_rst, b_busy, b_done, b_to;
  logic [1:0] b_bank;
  logic [7:0] b_cycles;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // dut_a: clamp + saturation target; dut_b: watchdog target
  core_run_ctrl #(.NUM_PROGS(3), .RST_CYCLES(2), .CYC_W(4), .TIMEOUT(0)) dut_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .prog_sel(prog_sel), .pc(pc),
    .core_rst(a_core_rst), .bank(a_bank), .busy(a_busy), .done(a_done),
    .timed_out(a_to), .cycles(a_cycles)
  );

  core_run_ctrl #(.NUM_PROGS(4), .RST_CYCLES(3), .CYC_W(8), .TIMEOUT(5)) dut_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .prog_sel(prog_sel), .pc(pc),
    .core_rst(b_core_rst), .bank(b_bank), .busy(b_busy), .done(b_done),
    .timed_out(b_to), .cycles(b_cycles)
  );

  int p_rc[2]   = '{2, 3};
  int p_cmax[2] = '{15, 255};
  int p_tmo[2]  = '{0, 5};
  int p_np[2]   = '{3, 4};

  // Reference model: remaining reset cycles, running flag, sticky flags.
  int m_hold[2];
  bit m_run[2];
  bit m_done[2];
  bit m_to[2];
  int m_cyc[2];
  int m_bank[2];
  bit m_start_q;

  typedef struct {
    int k;
    bit core_rst;
    bit busy;
    bit done;
    bit to;
    int cyc;
    int bank;
  } exp_t;

  exp_t exp_q[$];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_hold[k] = 0; m_run[k] = 0; m_done[k] = 0; m_to[k] = 0;
      m_cyc[k] = 0; m_bank[k] = 0;
    end
    m_start_q = 0;
  endtask

  task automatic model_edge(input int k);
    bit rise;
    rise = start && !m_start_q;
    if (!m_run[k] && m_hold[k] == 0) begin
      if (rise) begin
        m_hold[k] = p_rc[k];
        m_done[k] = 0;
        m_to[k]   = 0;
        m_cyc[k]  = 0;
        m_bank[k] = (int'(prog_sel) >= p_np[k]) ? p_np[k] - 1 : int'(prog_sel);
      end
    end else if (m_hold[k] > 0) begin
      if (abort) m_hold[k] = 0;
      else begin
        m_hold[k] = m_hold[k] - 1;
        if (m_hold[k] == 0) m_run[k] = 1;
      end
    end else begin
      if (abort) m_run[k] = 0;
      else if (pc == 8'hFF) begin
        m_run[k] = 0; m_done[k] = 1;
      end else if (p_tmo[k] != 0 && m_cyc[k] + 1 == p_tmo[k]) begin
        m_cyc[k] = p_tmo[k]; m_run[k] = 0; m_to[k] = 1;
      end else begin
        m_cyc[k] = (m_cyc[k] + 1 > p_cmax[k]) ? p_cmax[k] : m_cyc[k] + 1;
      end
    end
  endtask

  task automatic push_exp();
    for (int k = 0; k < 2; k++) begin
      exp_t e;
      e.k        = k;
      e.core_rst = !m_run[k];
      e.busy     = m_run[k] || (m_hold[k] > 0);
      e.done     = m_done[k];
      e.to       = m_to[k];
      e.cyc      = m_cyc[k];
      e.bank     = m_bank[k];
      exp_q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else begin
      model_edge(0);
      model_edge(1);
      m_start_q = start;
    end
    push_exp();
    #1;
  endtask

  // Called just after tick(): asserts rst mid-cycle and replaces this cycle's expectations.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    model_reset();
    push_exp();
    #1;
    checks++;
    if (a_core_rst !== 1'b1 || b_core_rst !== 1'b1 || a_busy !== 1'b0 || b_busy !== 1'b0) begin
      errors++;
      $display("FAIL async_rst t=%0t: got core_rst=%b/%b busy=%b/%b, need core_rst=1/1 busy=0/0",
               $time, a_core_rst, b_core_rst, a_busy, b_busy);
    end
  endtask

  exp_t e_m;
  logic g_rst, g_busy, g_done, g_to;
  int   g_cyc, g_bank;

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      e_m = exp_q.pop_front();
      if (e_m.k == 0) begin
        g_rst = a_core_rst; g_busy = a_busy; g_done = a_done; g_to = a_to;
        g_cyc = int'(a_cycles); g_bank = int'(a_bank);
      end else begin
        g_rst = b_core_rst; g_busy = b_busy; g_done = b_done; g_to = b_to;
        g_cyc = int'(b_cycles); g_bank = int'(b_bank);
      end
      checks++;
      if (g_rst !== e_m.core_rst || g_busy !== e_m.busy || g_done !== e_m.done ||
          g_to !== e_m.to || g_cyc != e_m.cyc || g_bank != e_m.bank) begin
        errors++;
        $display("FAIL dut%0d_outputs t=%0t: got core_rst=%b busy=%b done=%b to=%b cycles=%0d bank=%0d, need core_rst=%b busy=%b done=%b to=%b cycles=%0d bank=%0d",
                 e_m.k, $time, g_rst, g_busy, g_done, g_to, g_cyc, g_bank,
                 e_m.core_rst, e_m.busy, e_m.done, e_m.to, e_m.cyc, e_m.bank);
      end
    end
  end

  task automatic run_free(input int n);
    for (int i = 0; i < n; i++) begin
      pc = 8'($urandom_range(0, 254));
      tick();
    end
  endtask

  initial begin
    model_reset();
    // reset values
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    // normal run ending on the terminal PC
    prog_sel = 2'd2; start = 1'b1; tick();
    run_free(12);
    pc = 8'hFF; tick();
    pc = 8'h00; repeat (3) tick();

    // start held high must not restart; then a fresh edge with a clamped bank
    repeat (4) tick();
    start = 1'b0; tick();
    prog_sel = 2'd3; start = 1'b1; tick();
    run_free(20);
    pc = 8'hFF; tick();
    pc = 8'h00; start = 1'b0; tick();

    // terminal PC on dut_b's fifth run cycle beats the watchdog
    prog_sel = 2'd1; start = 1'b1; tick();
    run_free(7);
    pc = 8'hFF; tick();
    pc = 8'h00; start = 1'b0; tick();

    // watchdog expiry on dut_b
    start = 1'b1; tick();
    run_free(9);
    pc = 8'hFF; tick();
    pc = 8'h00; start = 1'b0; tick();

    // abort in run, then abort during reset hold
    start = 1'b1; tick();
    run_free(5);
    abort = 1'b1; tick();
    abort = 1'b0; repeat (2) tick();
    start = 1'b0; tick();
    start = 1'b1; tick();
    abort = 1'b1; tick();
    abort = 1'b0; repeat (2) tick();

    // asynchronous reset in the middle of a run
    start = 1'b0; tick();
    start = 1'b1; tick();
    run_free(6);
    async_reset();
    tick();
    rst = 1'b0;
    repeat (2) tick();

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) start = ~start;
      abort    = ($urandom_range(0, 24) == 0);
      pc       = ($urandom_range(0, 19) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
      prog_sel = 2'($urandom_range(0, 3));
      tick();
      if ($urandom_range(0, 199) == 0) begin
        async_reset();
        tick();
        rst = 1'b0;
      end
    end

    abort = 1'b0; start = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
